// File: rtl/cbus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// cbus_rr_arbiter_pkg : cbus request/response types and arbiter state encoding
// Rev 1.0
// ============================================================================
package cbus_rr_arbiter_pkg;

  localparam int CBUS_ARB_MAX_REQ = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/cbus_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// cbus_rr_arbiter_if : bundles the master-side and memory-side cbus signals
// Rev 1.0
// ============================================================================
interface cbus_rr_arbiter_if
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] oresps;
  cbus_req_t                oreq;
  cbus_resp_t               iresp;

  // slave: the arbiter's view; master: the caches + memory model view
  modport slave  (input ireqs, input iresp, output oresps, output oreq);
  modport master (output ireqs, output iresp, input oresps, input oreq);
endinterface
`default_nettype wire

// File: rtl/cbus_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin pick, first valid index from ptr upward
// Rev 1.0
// ============================================================================
module rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand        = '0;
    idx_o       = '0;
    any_valid_o = |valid_i;
    // Scan farthest-first so the candidate nearest ptr overwrites the rest.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (valid_i[cand]) begin
        idx_o = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// cbus_rr_arbiter : shares one cbus port between NUM_REQ masters, per-burst RR
// Rev 1.0
// ============================================================================
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input logic              clk,
  input logic              resetn,
  cbus_rr_arbiter_if.slave bus
);

  arb_state_t         state_q;
  logic [IDX_W-1:0]   sel_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] w_valid;
  logic               w_any;
  logic [IDX_W-1:0]   w_pick;
  logic               w_done;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_valid
    assign w_valid[i] = bus.ireqs[i].valid;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i     (w_valid),
    .ptr_i       (ptr_q),
    .any_valid_o (w_any),
    .idx_o       (w_pick)
  );

  assign w_done = bus.iresp.ready && bus.iresp.last;
  assign ptr_d  = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_any) begin
            sel_q   <= w_pick;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (w_done) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beats pass straight through while granted; IDLE isolates both sides.
  always_comb begin
    bus.oreq   = '0;
    bus.oresps = '0;
    if (state_q == BUSY) begin
      bus.oreq          = bus.ireqs[sel_q];
      bus.oresps[sel_q] = bus.iresp;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cbus_rr_arbiter : directed scenarios plus randomized run vs. a burst model
// Rev 1.0
// ============================================================================
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int N = 4;
  typedef cbus_resp_t [N-1:0] resp_vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cbus_rr_arbiter_if #(.NUM_REQ(N)) bus ();
  cbus_rr_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int vectors = 0;
  int errors  = 0;

  // Reference: which master owns the bus, and who is next in line.
  bit m_busy;
  int m_sel;
  int m_ptr;

  function automatic int first_valid(int from);
    for (int k = 0; k < N; k++)
      if (bus.ireqs[(from + k) % N].valid) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_sel <= 0; m_ptr <= 0;
    end else if (!m_busy) begin
      if (first_valid(m_ptr) >= 0) begin
        m_busy <= 1'b1; m_sel <= first_valid(m_ptr);
      end
    end else if (bus.iresp.ready && bus.iresp.last) begin
      m_busy <= 1'b0; m_ptr <= (m_sel + 1) % N;
    end
  end

  function automatic cbus_req_t exp_oreq();
    return m_busy ? bus.ireqs[m_sel] : cbus_req_t'('0);
  endfunction

  function automatic resp_vec_t exp_resps();
    resp_vec_t v;
    v = '0;
    if (m_busy) v[m_sel] = bus.iresp;
    return v;
  endfunction

  function automatic cbus_req_t mk_req(int i, bit wr);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = 32'h1000_0000 + 32'(i) * 32'h100;
    r.size     = 3'd2;
    r.len      = 8'(i + 1);
    r.strobe   = 4'hF;
    r.data     = 32'hA5A5_0000 + 32'(i);
    return r;
  endfunction

  function automatic cbus_resp_t beat(bit rdy, bit lst, logic [31:0] d);
    cbus_resp_t b;
    b.ready = rdy; b.last = lst; b.data = d;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; bus.ireqs = '0; bus.iresp = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic finish_burst();
    bus.iresp = beat(1'b1, 1'b1, 32'h0);
    tick();
    bus.iresp = '0; bus.ireqs = '0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.ireqs = '0;
    bus.ireqs[0] = mk_req(0, 1'b0);
    bus.ireqs[1] = mk_req(1, 1'b0);
    bus.iresp = beat(1'b1, 1'b1, 32'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      vectors++;
      if (bus.oreq !== '0 || bus.oresps !== '0) begin
        errors++;
        $display("FAIL reset_hold oreq=%h oresps=%h required all zero", bus.oreq, bus.oresps);
      end
    end
    bus.iresp = '0;
    resetn = 1'b1;
    #1 vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle oreq.valid=%b required 0", bus.oreq.valid);
    end
    tick(); #1 vectors++;
    if (bus.oreq !== mk_req(0, 1'b0)) begin
      errors++; $display("FAIL reset_first_grant oreq=%h required %h", bus.oreq, mk_req(0, 1'b0));
    end
    bus.iresp = beat(1'b1, 1'b1, 32'h0);
    tick();
    bus.iresp = '0; bus.ireqs[0].valid = 1'b0;
    #1 vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      errors++; $display("FAIL reset_bubble oreq.valid=%b required 0", bus.oreq.valid);
    end
    tick(); #1 vectors++;
    if (bus.oreq !== mk_req(1, 1'b0)) begin
      errors++; $display("FAIL reset_second_grant oreq=%h required %h", bus.oreq, mk_req(1, 1'b0));
    end
    finish_burst();
  endtask

  task automatic test_single_burst();
    cbus_req_t  r;
    cbus_resp_t want;
    do_reset();
    r = mk_req(1, 1'b0);
    r.addr = 32'h8000_0040; r.len = 8'd3;
    bus.ireqs[1] = r;
    tick();
    for (int b = 0; b < 4; b++) begin
      want = beat(1'b1, b == 3, 32'hD000_0000 + 32'(b));
      bus.iresp = want;
      #1 vectors++;
      if (bus.oresps[1] !== want || bus.oresps[0] !== '0 || bus.oreq !== r) begin
        errors++;
        $display("FAIL single_beat%0d resp1=%h resp0=%h oreq=%h required resp1=%h resp0=0 oreq=%h",
                 b, bus.oresps[1], bus.oresps[0], bus.oreq, want, r);
      end
      tick();
    end
    bus.ireqs[1].valid = 1'b0; bus.iresp = '0;
    #1 vectors++;
    if (bus.oreq.valid !== 1'b0 || bus.oresps !== '0) begin
      errors++; $display("FAIL single_idle_after_last oreq.valid=%b oresps=%h required 0", bus.oreq.valid, bus.oresps);
    end
    tick();
  endtask

  task automatic test_contention();
    cbus_req_t r [2];
    int order [3] = '{0, 1, 0};
    do_reset();
    r[0] = mk_req(0, 1'b1); r[1] = mk_req(1, 1'b0);
    bus.ireqs[0] = r[0]; bus.ireqs[1] = r[1];
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.iresp = beat(1'b1, 1'b0, 32'h11);
      #1 vectors++;
      if (bus.oreq !== r[order[k]]) begin
        errors++; $display("FAIL contention_grant%0d oreq=%h required %h", k, bus.oreq, r[order[k]]);
      end
      tick();
      bus.iresp = beat(1'b1, 1'b1, 32'h22);
      #1 vectors++;
      if (bus.oreq !== r[order[k]] || bus.oresps[order[k]].last !== 1'b1) begin
        errors++; $display("FAIL contention_last%0d oreq=%h oresps=%h", k, bus.oreq, bus.oresps);
      end
      tick();
      bus.iresp = '0;
      #1 vectors++;
      if (bus.oreq.valid !== 1'b0) begin
        errors++; $display("FAIL contention_bubble%0d oreq.valid=%b required 0", k, bus.oreq.valid);
      end
    end
    bus.ireqs = '0;
    tick();
  endtask

  task automatic test_ready_no_last();
    cbus_req_t r0;
    do_reset();
    r0 = mk_req(0, 1'b1);
    bus.ireqs[0] = r0; bus.ireqs[2] = mk_req(2, 1'b0);
    tick();
    for (int b = 0; b < 4; b++) begin
      bus.iresp = beat(1'b1, b == 3, 32'h3000 + 32'(b));
      #1 vectors++;
      if (bus.oreq !== r0 || bus.oresps[0].ready !== 1'b1 || bus.oresps[2] !== '0) begin
        errors++; $display("FAIL stall_beat%0d oreq=%h oresps=%h required oreq=%h", b, bus.oreq, bus.oresps, r0);
      end
      tick();
      if (b < 3) begin
        for (int s = 0; s < 2; s++) begin
          bus.iresp = beat(1'b0, 1'b1, 32'h0);
          #1 vectors++;
          if (bus.oreq !== r0 || bus.oresps[2] !== '0) begin
            errors++; $display("FAIL stall_wait%0d_%0d oreq=%h required %h", b, s, bus.oreq, r0);
          end
          tick();
        end
      end
    end
    bus.ireqs[0].valid = 1'b0; bus.iresp = '0;
    #1 vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      errors++; $display("FAIL stall_idle oreq.valid=%b required 0", bus.oreq.valid);
    end
    tick(); #1 vectors++;
    if (bus.oreq !== mk_req(2, 1'b0)) begin
      errors++; $display("FAIL stall_next_grant oreq=%h required %h", bus.oreq, mk_req(2, 1'b0));
    end
    finish_burst();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.ireqs[0] = mk_req(0, 1'b1);
    tick();
    bus.iresp = beat(1'b1, 1'b0, 32'h1);
    tick();
    bus.iresp = beat(1'b1, 1'b0, 32'h2);
    #1 resetn = 1'b0;
    #1 vectors++;
    if (bus.oreq !== '0 || bus.oresps !== '0) begin
      errors++; $display("FAIL midreset_async oreq=%h oresps=%h required all zero", bus.oreq, bus.oresps);
    end
    bus.ireqs = '0; bus.ireqs[1] = mk_req(1, 1'b0); bus.iresp = '0;
    tick();
    resetn = 1'b1;
    tick(); #1 vectors++;
    if (bus.oreq !== mk_req(1, 1'b0)) begin
      errors++; $display("FAIL midreset_regrant oreq=%h required %h", bus.oreq, mk_req(1, 1'b0));
    end
    finish_burst();
  endtask

  task automatic test_wrap();
    cbus_req_t r0, r3;
    do_reset();
    r0 = mk_req(0, 1'b0); r3 = mk_req(3, 1'b1);
    bus.ireqs[3] = r3;
    tick(); #1 vectors++;
    if (bus.oreq !== r3) begin
      errors++; $display("FAIL wrap_first oreq=%h required %h", bus.oreq, r3);
    end
    bus.iresp = beat(1'b1, 1'b1, 32'h0);
    tick();
    bus.iresp = '0; bus.ireqs[0] = r0;
    tick(); #1 vectors++;
    if (bus.oreq !== r0) begin
      errors++; $display("FAIL wrap_ptr0_wins oreq=%h required %h", bus.oreq, r0);
    end
    bus.iresp = beat(1'b1, 1'b1, 32'h0);
    tick();
    bus.iresp = '0;
    tick(); #1 vectors++;
    if (bus.oreq !== r3) begin
      errors++; $display("FAIL wrap_ptr1_wins oreq=%h required %h", bus.oreq, r3);
    end
    finish_burst();
  endtask

  task automatic test_random();
    bit done [N];
    cbus_req_t r;
    do_reset();
    for (int i = 0; i < N; i++) done[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.ireqs[i].valid || done[i]) begin
          if ($urandom_range(2) == 0) begin
            r = '0;
            r.valid = 1'b1; r.is_write = 1'($urandom); r.addr = $urandom;
            r.size = 3'($urandom); r.len = 8'($urandom); r.strobe = 4'($urandom);
            r.data = $urandom;
            bus.ireqs[i] = r;
          end else begin
            bus.ireqs[i].valid = 1'b0;
          end
        end
      end
      bus.iresp = beat(1'($urandom), ($urandom_range(2) == 0), $urandom);
      #1 vectors++;
      if (bus.oreq !== exp_oreq() || bus.oresps !== exp_resps()) begin
        errors++;
        $display("FAIL random cyc=%0d oreq=%h want %h oresps=%h want %h",
                 cyc, bus.oreq, exp_oreq(), bus.oresps, exp_resps());
      end
      for (int i = 0; i < N; i++)
        done[i] = m_busy && (m_sel == i) && bus.iresp.ready && bus.iresp.last;
      tick();
    end
    bus.ireqs = '0; bus.iresp = '0;
  endtask

  initial begin
    resetn = 1'b0;
    bus.ireqs = '0;
    bus.iresp = '0;
    test_reset();
    test_single_burst();
    test_contention();
    test_ready_no_last();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Round-robin arbiter that shares the single cache-bus (cbus) port to memory between NUM_REQ cache requesters, for example the instruction cache and the data cache. It sits between the caches' cbus master ports and the top-level creq/cresp pair. It grants one requester per burst transaction and holds the grant until the burst finishes. Responses go only to the granted requester.

## Interface
Parameters:
- NUM_REQ, 2, number of cbus masters; 2..8.
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived; not overridden).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous assertion, active-low.
- ireqs  in  cbus_req_t[NUM_REQ]  requests from the masters.
- oresps  out  cbus_resp_t[NUM_REQ]  responses to the masters.
- oreq  out  cbus_req_t  request to the memory side.
- iresp  in  cbus_resp_t  response from the memory side.

## Operation
- State machine has two states, IDLE and BUSY.
- Registers:
  - state
  - grant index `sel` (IDX_W bits)
  - round-robin pointer `ptr` (IDX_W bits): the highest-priority requester for the next grant.
- IDLE:
  - oreq is all-zero (valid=0).
  - Every oresps[i] is all-zero.
  - If any ireqs[i].valid is set, choose the first valid index scanning ptr, ptr+1, … modulo NUM_REQ.
  - Load that index into `sel` and go to BUSY.
- BUSY:
  - oreq = ireqs[sel], passed combinationally and unmodified (addr, len, size, strobe, data, is_write).
  - oresps[sel] = iresp; all other oresps are all-zero.
- Completion: in BUSY, when iresp.ready && iresp.last in the same cycle:
  - go to IDLE;
  - ptr <= (sel+1) mod NUM_REQ, wrapping when sel = NUM_REQ-1.
- ready without last (burst in progress): stay in BUSY, no change.
- Requesters follow the cbus rule of holding valid and the request fields stable until they see last.
  - The arbiter does not latch the request fields.
  - If ireqs[sel].valid drops in BUSY (a protocol violation), oreq.valid drops with it, and the grant is held until ready && last.
- Requests from non-granted masters stay pending. They are never acknowledged and never see ready.

## Timing
- Reset (resetn low) forces:
  - state=IDLE, sel=0, ptr=0;
  - oreq.valid=0 and all oresps zero, immediately (combinational from state).
- Reset during BUSY aborts the burst. The memory side must also be reset.
- Grant latency: a request valid in cycle t (state IDLE) appears on oreq in cycle t+1.
- Completion: ready && last in cycle t puts the arbiter in IDLE at t+1. The earliest next grant is visible at t+2.
  - This mandatory bubble lets the finished master deassert valid before it is rearbitrated.
- Simultaneous requests in IDLE: ptr decides the winner. There is no combinational path from iresp into the grant decision in IDLE.
- Single requester: back-to-back bursts from the same master are allowed, with the 1-cycle bubble between them.
- Fairness: with all masters constantly requesting, each waits at most NUM_REQ-1 bursts.
- Combinational paths:
  - ireqs[sel] → oreq and iresp → oresps[sel] are combinational; there is no added latency per beat.
  - No path from iresp to oreq.

## Structure
- cbus_req_t and cbus_resp_t come from the shared common package, unchanged.
- Add to the shared package:
  - CBUS_ARB_MAX_REQ = 8;
  - an enum arb_state_t {IDLE, BUSY}.
- One sub-module: rr_pick.
  - Purely combinational.
  - Inputs: valid vector [NUM_REQ] and ptr.
  - Outputs: any_valid and the winning index.
  - Reusable by later uncached/cached bus muxes.
- Expected size: ~150 lines for the arbiter plus ~50 for rr_pick.

## Test plan
- Reset check: hold resetn=0 with both ireqs valid → oreq.valid=0 and oresps all zero. Release → the grant goes to master 0 (ptr=0), and its oreq.addr appears one cycle after IDLE sampling.
- Single burst: master 1 issues a read with addr=0x8000_0040, len=3, and memory returns 4 beats with last on beat 4 → master 1 receives 4 ready beats carrying the memory data; master 0 sees ready=0 throughout; the arbiter is IDLE the cycle after last.
- Contention round-robin: both masters hold valid for 3 consecutive bursts → grant order 0,1,0, with exactly one IDLE cycle between bursts; ptr is 1,0,1 after each completion.
- Ready without last: memory asserts ready on beats 1-3 without last, stalling 2 cycles between beats → the grant does not switch and oreq stays equal to the granted request until last.
- Mid-burst reset: assert resetn=0 during beat 2 of master 0's write burst → oreq.valid=0 in the same cycle; after release with only master 1 valid → master 1 is granted, with ptr=0 not blocking it.
- Wrap-around with NUM_REQ=4: masters 3 and 0 valid after a completion by master 3 (ptr=0) → master 0 wins; next completion sets ptr=1 → master 3 wins next.
